uart_rx_model: RTL and testbench

Cycle-based asynchronous serial receiver used as a bench-side UART monitor. It samples the SoC UART transmit line and reassembles frames using a programmable bit period, data width and stop-bit count. It reports each completed character with a one-cycle ready pulse and a framing-error flag. It is synthesizable RTL so the same block runs under Verilator and event-driven simulators.

---
 rtl/uart_rx_pkg.sv | 36 +++
 rtl/uart_rx_model.sv | 140 ++++++++++++++
 tb/tb_uart_rx_model.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_model shared types and helpers.
// State encoding, defaults and control normalization.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } uart_rx_state_e;

    localparam int DEF_BAUD  = 2;
    localparam int DEF_BITS  = 8;
    localparam int DEF_STOPS = 1;

    // Zero means one for the bit period and stop count.
    function automatic logic [31:0] nz(
        input logic [31:0] v
    );
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

    // Zero means one; anything wider than the data register is clamped.
    function automatic logic [5:0] norm_bits(
        input logic [5:0]  b,
        input int unsigned max_bits
    );
        if (b == 6'd0)
            return 6'd1;
        if (32'(b) > max_bits)
            return 6'(max_bits);
        return b;
    endfunction

endpackage

// File: rtl/uart_rx_model.sv
// uart_rx_model: cycle-based UART receive monitor.
// Programmable bit period, data width and stop count.
module uart_rx_model
    import uart_rx_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  ctrl_baud_clks,
    input  logic [5:0]        ctrl_bits,
    input  logic [1:0]        ctrl_stops,
    input  logic              rxd,
    output logic              rx_rdy,
    output logic              rx_err,
    output logic [DATA_W-1:0] rx_data
);

    uart_rx_state_e    state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  n_l;
    logic [5:0]        b_l;
    logic [1:0]        s_l;
    logic [5:0]        idx;
    logic [DATA_W-1:0] shreg;
    logic              err_acc;
    logic              fin;

    logic [CNT_W-1:0]  n_in;
    logic [CNT_W-1:0]  h_in;
    logic [5:0]        b_in;
    logic [1:0]        s_in;
    logic              tick;
    logic [DATA_W-1:0] bit_mask;

    // Normalized controls, sample tick and data bit position.
    always_comb begin
        n_in     = CNT_W'(nz(32'(ctrl_baud_clks)));
        h_in     = n_in >> 1;
        b_in     = norm_bits(ctrl_bits, DATA_W);
        s_in     = 2'(nz(32'(ctrl_stops)));
        tick     = (cnt == '0);
        bit_mask = DATA_W'(1) << idx;
    end

    // Frame FSM: cnt counts down to the next sample point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            n_l     <= '0;
            b_l     <= '0;
            s_l     <= '0;
            idx     <= '0;
            shreg   <= '0;
            err_acc <= 1'b0;
            fin     <= 1'b0;
            rx_rdy  <= 1'b0;
            rx_err  <= 1'b0;
            rx_data <= '0;
        end else begin
            rx_rdy <= 1'b0;
            rx_err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (!rxd) begin
                        n_l     <= n_in;
                        b_l     <= b_in;
                        s_l     <= s_in;
                        shreg   <= '0;
                        idx     <= '0;
                        err_acc <= 1'b0;
                        fin     <= 1'b0;
                        // N=1: this edge is already the start sample.
                        if (h_in == '0) begin
                            state <= ST_DATA;
                            cnt   <= n_in - CNT_W'(1);
                        end else begin
                            state <= ST_START;
                            cnt   <= h_in - CNT_W'(1);
                        end
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (rxd) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_DATA;
                            cnt   <= n_l - CNT_W'(1);
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (rxd)
                            shreg <= shreg | bit_mask;
                        cnt <= n_l - CNT_W'(1);
                        if (idx == b_l - 6'd1) begin
                            idx   <= '0;
                            state <= ST_STOP;
                        end else begin
                            idx <= idx + 6'd1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (fin) begin
                        fin     <= 1'b0;
                        rx_rdy  <= 1'b1;
                        rx_err  <= err_acc;
                        rx_data <= shreg;
                        state   <= err_acc ? ST_WAIT_HIGH
                                           : ST_IDLE;
                    end else if (tick) begin
                        err_acc <= err_acc | ~rxd;
                        cnt     <= n_l - CNT_W'(1);
                        if (idx == {4'd0, s_l} - 6'd1)
                            fin <= 1'b1;
                        else
                            idx <= idx + 6'd1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rxd)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_model.sv
// Self-checking bench for uart_rx_model.
// Directed frame table plus multi-cycle corner sequences.
module tb_uart_rx_model;

    logic        clk;
    logic        rst_n;
    logic [15:0] ctrl_baud_clks;
    logic [5:0]  ctrl_bits;
    logic [1:0]  ctrl_stops;
    logic        rxd;
    logic        rx_rdy;
    logic        rx_err;
    logic [31:0] rx_data;

    uart_rx_model #(.CNT_W(16), .DATA_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ctrl_baud_clks (ctrl_baud_clks),
        .ctrl_bits      (ctrl_bits),
        .ctrl_stops     (ctrl_stops),
        .rxd            (rxd),
        .rx_rdy         (rx_rdy),
        .rx_err         (rx_err),
        .rx_data        (rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } pulse_t;

    typedef struct {
        int          baud;
        int          bits;
        int          stops;
        int          sn;
        int          sb;
        int          ss;
        logic [31:0] data;
        logic        sv;
        logic [31:0] exp_d;
        logic        exp_e;
        int          exp_lat;
    } vec_t;

    pulse_t q[$];
    int     cyc;
    int     total;
    int     bad;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_rdy) begin
            pulse_t p;
            p.cyc  = cyc;
            p.data = rx_data;
            p.err  = rx_err;
            q.push_back(p);
        end
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic idle(input int k);
        rxd = 1'b1;
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic b, input int n);
        rxd = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input int n,
                        input int nb, input int ns,
                        input logic sv, output int st);
        st = cyc + 1;
        drv(1'b0, n);
        for (int i = 0; i < nb; i++)
            drv(d[i], n);
        for (int i = 0; i < ns; i++)
            drv(sv, n);
    endtask

    task automatic pop_chk(input string nm, input int st,
                           input logic [31:0] ed,
                           input logic ee, input int el);
        pulse_t p;
        if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s no pulse act=0 exp=1", nm);
        end else begin
            p = q.pop_front();
            chk({nm, "_data"}, p.data, ed);
            chk({nm, "_err"}, 32'(p.err), 32'(ee));
            chk({nm, "_lat"}, p.cyc - st, el);
        end
    endtask

    task automatic set_ctrl(input int n, input int b,
                            input int s);
        ctrl_baud_clks = 16'(n);
        ctrl_bits      = 6'(b);
        ctrl_stops     = 2'(s);
    endtask

    vec_t vt[9];
    int   st;
    int   st2;

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst_n = 1'b0;
        rxd   = 1'b1;
        set_ctrl(2, 8, 1);

        vt[0] = '{2, 8, 1, 2, 8, 1, 32'h41, 1'b1,
                  32'h41, 1'b0, 20};
        vt[1] = '{3, 7, 2, 3, 7, 2, 32'h55, 1'b1,
                  32'h55, 1'b0, 29};
        vt[2] = '{0, 0, 0, 1, 1, 1, 32'h1, 1'b1,
                  32'h1, 1'b0, 3};
        vt[3] = '{5, 40, 1, 5, 32, 1, 32'hDEADBEEF, 1'b1,
                  32'hDEADBEEF, 1'b0, 168};
        vt[4] = '{1, 8, 2, 1, 8, 2, 32'hC3, 1'b1,
                  32'hC3, 1'b0, 11};
        vt[5] = '{6, 5, 3, 6, 5, 3, 32'h35, 1'b1,
                  32'h15, 1'b0, 52};
        vt[6] = '{7, 8, 1, 7, 8, 1, 32'h00, 1'b1,
                  32'h00, 1'b0, 67};
        vt[7] = '{2, 6, 2, 2, 6, 2, 32'h2D, 1'b0,
                  32'h2D, 1'b1, 18};
        vt[8] = '{1, 4, 1, 1, 4, 1, 32'hA, 1'b0,
                  32'hA, 1'b1, 6};

        #1;
        chk("rst_rdy", 32'(rx_rdy), 32'd0);
        chk("rst_err", 32'(rx_err), 32'd0);
        chk("rst_data", rx_data, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);

        for (int i = 0; i < 9; i++) begin
            set_ctrl(vt[i].baud, vt[i].bits, vt[i].stops);
            idle(2);
            send(vt[i].data, vt[i].sn, vt[i].sb, vt[i].ss,
                 vt[i].sv, st);
            idle(2 * vt[i].sn + 8);
            chk($sformatf("vec%0d_cnt", i), q.size(), 1);
            pop_chk($sformatf("vec%0d", i), st, vt[i].exp_d,
                    vt[i].exp_e, vt[i].exp_lat);
            q.delete();
        end

        // framing error then line held low
        set_ctrl(4, 8, 1);
        idle(2);
        send(32'hA5, 4, 8, 1, 1'b0, st);
        rxd = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("ferr_cnt", q.size(), 1);
        pop_chk("ferr", st, 32'hA5, 1'b1, 39);
        q.delete();
        idle(8);
        chk("ferr_quiet", q.size(), 0);
        send(32'h3C, 4, 8, 1, 1'b1, st);
        idle(16);
        chk("ferr_next_cnt", q.size(), 1);
        pop_chk("ferr_next", st, 32'h3C, 1'b0, 39);
        q.delete();

        // one-cycle glitch on an idle line
        rxd = 1'b0;
        @(posedge clk);
        #1;
        idle(60);
        chk("glitch_cnt", q.size(), 0);
        send(32'h5A, 4, 8, 1, 1'b1, st);
        idle(16);
        chk("glitch_next_cnt", q.size(), 1);
        pop_chk("glitch_next", st, 32'h5A, 1'b0, 39);
        q.delete();

        // back-to-back 7N2 frames
        set_ctrl(3, 7, 2);
        idle(2);
        send(32'h55, 3, 7, 2, 1'b1, st);
        send(32'h2A, 3, 7, 2, 1'b1, st2);
        idle(14);
        chk("b2b_cnt", q.size(), 2);
        pop_chk("b2b_a", st, 32'h55, 1'b0, 29);
        pop_chk("b2b_b", st2, 32'h2A, 1'b0, 29);
        q.delete();

        // reset during data bit 3
        set_ctrl(4, 8, 1);
        idle(2);
        drv(1'b0, 4);
        drv(1'b1, 4);
        drv(1'b1, 4);
        drv(1'b1, 4);
        rxd = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_rdy", 32'(rx_rdy), 32'd0);
        chk("mrst_err", 32'(rx_err), 32'd0);
        chk("mrst_data", rx_data, 32'd0);
        idle(40);
        chk("mrst_quiet", q.size(), 0);
        rst_n = 1'b1;
        idle(5);
        send(32'h33, 4, 8, 1, 1'b1, st);
        idle(16);
        chk("mrst_next_cnt", q.size(), 1);
        pop_chk("mrst_next", st, 32'h33, 1'b0, 39);
        q.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
